// File: rtl/ads1675_rx.sv
// ============================================================================
// ads1675_rx
// ----------------------------------------------------------------------------
// Capture front end for the ADS1675 serial output. The ADC's sclk, drdy and
// dout arrive asynchronous to aclk. They are oversampled in the aclk domain,
// and each BITS-long MSB-first conversion word is deserialized. The word is
// sign-extended to OUT_W bits and presented on an AXI4-Stream master.
//
// Optional feature macro: ADS1675_RX_TLAST_EN
//   defined   -> a frame counter drives m_axis_tlast every FRAME_LEN transfers
//   undefined -> m_axis_tlast is tied to 0 and no counter is built
//
// Ports
//   aclk           in   only clock
//   areset         in   synchronous active-high reset
//   enable         in   capture enable
//   clr_status     in   one-cycle pulse, clears overflow and frame_err
//   sclk           in   ADC serial clock (asynchronous)
//   drdy           in   ADC data ready, active low (asynchronous)
//   dout           in   ADC serial data (asynchronous)
//   m_axis_tdata   out  sign-extended sample
//   m_axis_tvalid  out  sample valid
//   m_axis_tready  in   downstream ready
//   m_axis_tlast   out  last sample of a frame (feature macro only)
//   overflow       out  sticky: a completed sample was dropped
//   frame_err      out  sticky: drdy fell before a word was complete
//   sample_cnt     out  number of accepted transfers, wraps at 2^32
// ============================================================================
module ads1675_rx #(
    parameter int BITS      = 24,
    parameter int OUT_W     = 32,
    parameter int FRAME_LEN = 300
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             enable,
    input  logic             clr_status,
    input  logic             sclk,
    input  logic             drdy,
    input  logic             dout,
    output logic [OUT_W-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic             overflow,
    output logic             frame_err,
    output logic [31:0]      sample_cnt
);

    localparam int CNT_W = $clog2(BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITS - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchronizers: bit 0 = sclk, bit 1 = drdy, bit 2 = dout
    // ------------------------------------------------------------------
    logic [2:0] w_async;
    logic [2:0] w_sync_s2;

    assign w_async = {dout, drdy, sclk};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            logic r_s1;
            logic r_s2;
            always_ff @(posedge aclk) begin
                if (areset) begin
                    r_s1 <= 1'b0;
                    r_s2 <= 1'b0;
                end else begin
                    r_s1 <= w_async[gi];
                    r_s2 <= r_s1;
                end
            end
            assign w_sync_s2[gi] = r_s2;
        end
    endgenerate

    // History flops for edge detection on sclk and drdy
    logic r_sclk_s3;
    logic r_drdy_s3;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_sclk_s3 <= 1'b0;
            r_drdy_s3 <= 1'b0;
        end else begin
            r_sclk_s3 <= w_sync_s2[0];
            r_drdy_s3 <= w_sync_s2[1];
        end
    end

    logic w_sclk_rise;
    logic w_drdy_fall;
    logic w_dout_s2;

    assign w_sclk_rise = w_sync_s2[0] & ~r_sclk_s3;
    // drdy syncs reset to 0, so the first rise after reset is not a fall
    assign w_drdy_fall = ~w_sync_s2[1] & r_drdy_s3;
    assign w_dout_s2   = w_sync_s2[2];

    // ------------------------------------------------------------------
    // Deserializer state
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [CNT_W-1:0] r_bitcnt;
    // Only BITS-1 bits are kept: the final bit comes straight from dout_s2
    logic [BITS-2:0]  r_shreg;

    logic [OUT_W-1:0] r_tdata;
    logic             r_tvalid;
    logic             r_overflow;
    logic             r_frame_err;
    logic [31:0]      r_sample_cnt;

    logic [BITS-1:0]  w_word;
    logic             w_in_shift;
    logic             w_done;
    logic             w_ferr_set;
    logic             w_accept;
    logic             w_load;
    logic             w_drop;

    assign w_word     = {r_shreg, w_dout_s2};
    assign w_in_shift = (r_state == S_SHIFT) && enable;
    // drdy_fall takes precedence over a coincident sclk_rise: the frame restarts
    assign w_ferr_set = w_in_shift && w_drdy_fall;
    assign w_done     = w_in_shift && !w_drdy_fall && w_sclk_rise
                        && (r_bitcnt == LAST_BIT);
    assign w_accept   = r_tvalid && m_axis_tready;
    // A word completing in the same cycle as a handshake replaces the old one
    assign w_load     = w_done && (!r_tvalid || m_axis_tready);
    assign w_drop     = w_done && !w_load;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state      <= S_IDLE;
            r_bitcnt     <= '0;
            r_shreg      <= '0;
            r_tdata      <= '0;
            r_tvalid     <= 1'b0;
            r_overflow   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_sample_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_drdy_fall && enable) begin
                        r_state  <= S_SHIFT;
                        r_bitcnt <= '0;
                        r_shreg  <= '0;
                    end
                end
                S_SHIFT: begin
                    if (!enable) begin
                        // Silent abort; the partial word is discarded
                        r_state  <= S_IDLE;
                        r_bitcnt <= '0;
                    end else if (w_drdy_fall) begin
                        r_bitcnt <= '0;
                        r_shreg  <= '0;
                    end else if (w_sclk_rise) begin
                        r_shreg <= w_word[BITS-2:0];
                        if (r_bitcnt == LAST_BIT) begin
                            r_state  <= S_IDLE;
                            r_bitcnt <= '0;
                        end else begin
                            r_bitcnt <= r_bitcnt + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_load) begin
                r_tdata  <= {{(OUT_W-BITS){w_word[BITS-1]}}, w_word};
                r_tvalid <= 1'b1;
            end else if (w_accept) begin
                r_tvalid <= 1'b0;
            end

            if (w_accept) begin
                r_sample_cnt <= r_sample_cnt + 32'd1;
            end

            // Sets win over a simultaneous clear
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_status) begin
                r_overflow <= 1'b0;
            end

            if (w_ferr_set) begin
                r_frame_err <= 1'b1;
            end else if (clr_status) begin
                r_frame_err <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign overflow      = r_overflow;
    assign frame_err     = r_frame_err;
    assign sample_cnt    = r_sample_cnt;

    // ------------------------------------------------------------------
    // Optional frame marker
    // ------------------------------------------------------------------
`ifdef ADS1675_RX_TLAST_EN
    localparam int FC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAME_LEN - 1);

    logic [FC_W-1:0] r_frame_cnt;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_frame_cnt <= '0;
        end else if (!enable) begin
            r_frame_cnt <= '0;
        end else if (w_accept) begin
            if (r_frame_cnt == FC_LAST) begin
                r_frame_cnt <= '0;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    // Counter indexes the sample currently on the bus; dropped words never
    // reach the bus, so they never advance it
    assign m_axis_tlast = r_tvalid && (r_frame_cnt == FC_LAST);
`else
    logic w_unused_frame_len;
    assign w_unused_frame_len = ^FRAME_LEN;
    assign m_axis_tlast       = 1'b0;
`endif

endmodule

// File: tb/tb_ads1675_rx.sv
// ============================================================================
// tb_ads1675_rx
// Directed testbench for ads1675_rx. Drives an ADS1675-like serial frame
// (drdy low pulse, then BITS sclk cycles with dout changing on falling
// edges) and checks the AXI4-Stream output, status flags and counters.
// ============================================================================
`timescale 1ns/1ps
module tb_ads1675_rx;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        enable = 1'b0;
    logic        clr_status = 1'b0;
    logic        sclk = 1'b0;
    logic        drdy = 1'b1;
    logic        dout = 1'b0;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic        overflow;
    logic        frame_err;
    logic [31:0] sample_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int half     = 3;   // sclk half period in aclk cycles (aclk/6 by default)
    int exp_cnt  = 0;

    logic [31:0] got_q[$];
    logic        last_q[$];
    int          valid_cycles = 0;

    always #5 aclk = ~aclk;

    ads1675_rx dut (
        .aclk          (aclk),
        .areset        (areset),
        .enable        (enable),
        .clr_status    (clr_status),
        .sclk          (sclk),
        .drdy          (drdy),
        .dout          (dout),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .overflow      (overflow),
        .frame_err     (frame_err),
        .sample_cnt    (sample_cnt)
    );

    // Record accepted transfers on the falling edge, away from the active edge
    always @(negedge aclk) begin
        if (!areset) begin
            if (m_axis_tvalid) valid_cycles++;
            if (m_axis_tvalid && m_axis_tready) begin
                got_q.push_back(m_axis_tdata);
                last_q.push_back(m_axis_tlast);
            end
        end
    end

    function automatic logic [31:0] sx(input logic [23:0] w);
        return {{8{w[23]}}, w};
    endfunction

    task automatic clk_n(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic clear_mon();
        got_q.delete();
        last_q.delete();
        valid_cycles = 0;
    endtask

    task automatic drdy_pulse();
        drdy = 1'b0;
        clk_n(3);
        drdy = 1'b1;
    endtask

    task automatic send_bits(input logic [23:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            dout = w[23-i];
            sclk = 1'b0;
            clk_n(half);
            sclk = 1'b1;
            clk_n(half);
        end
        sclk = 1'b0;
    endtask

    task automatic send_frame(input logic [23:0] w);
        drdy_pulse();
        send_bits(w, 24);
        clk_n(8);
    endtask

    // Expect exactly one delivered word equal to exp
    task automatic expect_one(input string name, input logic [31:0] exp);
        n_checks++;
        if (got_q.size() != 1) begin
            n_fail++;
            $display("FAIL %s: transfers=%0d required=1", name, got_q.size());
        end else if (got_q[0] !== exp) begin
            n_fail++;
            $display("FAIL %s: tdata=%h required=%h", name, got_q[0], exp);
        end else begin
            $display("ok   %s: tdata=%h", name, got_q[0]);
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        clk_n(4);
        n_checks += 6;
        if (m_axis_tdata !== 32'h0)  begin n_fail++; $display("FAIL reset_tdata: %h required 0", m_axis_tdata); end
        if (m_axis_tvalid !== 1'b0)  begin n_fail++; $display("FAIL reset_tvalid: %b required 0", m_axis_tvalid); end
        if (m_axis_tlast !== 1'b0)   begin n_fail++; $display("FAIL reset_tlast: %b required 0", m_axis_tlast); end
        if (overflow !== 1'b0)       begin n_fail++; $display("FAIL reset_overflow: %b required 0", overflow); end
        if (frame_err !== 1'b0)      begin n_fail++; $display("FAIL reset_frame_err: %b required 0", frame_err); end
        if (sample_cnt !== 32'h0)    begin n_fail++; $display("FAIL reset_sample_cnt: %0d required 0", sample_cnt); end
        $display("reset checked");
        areset = 1'b0;
        enable = 1'b1;
        clk_n(4);
    endtask

    task automatic test_single_frame();
        clear_mon();
        m_axis_tready = 1'b1;
        send_frame(24'h80_0001);
        exp_cnt++;
        expect_one("single_frame", 32'hFF80_0001);
        n_checks += 2;
        if (valid_cycles != 1) begin n_fail++; $display("FAIL single_tvalid_cycles: %0d required 1", valid_cycles); end
        if (sample_cnt !== 32'(exp_cnt)) begin n_fail++; $display("FAIL single_sample_cnt: %0d required %0d", sample_cnt, exp_cnt); end
    endtask

    task automatic test_positive();
        clear_mon();
        send_frame(24'h7F_FFFF);
        exp_cnt++;
        expect_one("positive_word", 32'h007F_FFFF);
    endtask

    task automatic test_random();
        logic [23:0] w;
        int tlast_seen = 0;
        for (int k = 0; k < 100; k++) begin
            clear_mon();
            w = 24'($urandom);
            send_frame(w);
            exp_cnt++;
            expect_one("random_word", sx(w));
            if (last_q.size() > 0 && last_q[0] === 1'b1) tlast_seen++;
        end
        n_checks += 3;
        if (overflow !== 1'b0)  begin n_fail++; $display("FAIL random_overflow: %b required 0", overflow); end
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL random_frame_err: %b required 0", frame_err); end
        if (sample_cnt !== 32'(exp_cnt)) begin n_fail++; $display("FAIL random_sample_cnt: %0d required %0d", sample_cnt, exp_cnt); end
`ifndef ADS1675_RX_TLAST_EN
        n_checks++;
        if (tlast_seen != 0) begin n_fail++; $display("FAIL tlast_tied_low: seen=%0d required 0", tlast_seen); end
`endif
    endtask

    task automatic test_backpressure();
        clear_mon();
        m_axis_tready = 1'b0;
        send_frame(24'hA5_5A5A);
        n_checks += 3;
        if (m_axis_tvalid !== 1'b1) begin n_fail++; $display("FAIL bp_first_valid: %b required 1", m_axis_tvalid); end
        if (m_axis_tdata !== 32'hFFA5_5A5A) begin n_fail++; $display("FAIL bp_first_data: %h required FFA55A5A", m_axis_tdata); end
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL bp_first_overflow: %b required 0", overflow); end
        send_frame(24'h12_3456);
        n_checks += 3;
        if (m_axis_tdata !== 32'hFFA5_5A5A) begin n_fail++; $display("FAIL bp_held_data: %h required FFA55A5A", m_axis_tdata); end
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_overflow: %b required 1", overflow); end
        if (got_q.size() != 0) begin n_fail++; $display("FAIL bp_no_transfer: %0d required 0", got_q.size()); end
        m_axis_tready = 1'b1;
        clk_n(3);
        exp_cnt++;
        expect_one("bp_release", 32'hFFA5_5A5A);
        n_checks += 2;
        if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_cleared: %b required 0", m_axis_tvalid); end
        if (sample_cnt !== 32'(exp_cnt)) begin n_fail++; $display("FAIL bp_sample_cnt: %0d required %0d", sample_cnt, exp_cnt); end
        clr_status = 1'b1;
        clk_n(1);
        clr_status = 1'b0;
        clk_n(1);
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL bp_clr_overflow: %b required 0", overflow); end
        $display("backpressure done");
    endtask

    task automatic test_frame_err();
        clear_mon();
        drdy_pulse();
        send_bits(24'hFF_FFFF, 10);
        clk_n(2);
        send_frame(24'h3C_0FF0);
        exp_cnt++;
        n_checks += 2;
        if (frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_set: %b required 1", frame_err); end
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL ferr_overflow: %b required 0", overflow); end
        expect_one("ferr_next_word", 32'h003C_0FF0);
        clr_status = 1'b1;
        clk_n(1);
        clr_status = 1'b0;
        clk_n(1);
        n_checks++;
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_clr: %b required 0", frame_err); end
    endtask

    task automatic test_enable_drop();
        clear_mon();
        drdy_pulse();
        send_bits(24'hC3_5A96, 12);
        enable = 1'b0;
        send_bits(24'h5A9_000, 12);
        clk_n(8);
        n_checks += 3;
        if (valid_cycles != 0) begin n_fail++; $display("FAIL en_no_valid: cycles=%0d required 0", valid_cycles); end
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL en_overflow: %b required 0", overflow); end
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL en_frame_err: %b required 0", frame_err); end
        enable = 1'b1;
        clk_n(2);
        send_frame(24'h00_0ABC);
        exp_cnt++;
        expect_one("en_reenable_word", 32'h0000_0ABC);
    endtask

    task automatic test_reset_mid();
        clear_mon();
        m_axis_tready = 1'b0;
        send_frame(24'hFE_DCBA);
        send_frame(24'h01_2345);
        drdy_pulse();
        send_bits(24'hFF_00FF, 8);
        areset = 1'b1;
        clk_n(1);
        n_checks += 5;
        if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL rm_tvalid: %b required 0", m_axis_tvalid); end
        if (m_axis_tdata !== 32'h0) begin n_fail++; $display("FAIL rm_tdata: %h required 0", m_axis_tdata); end
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL rm_overflow: %b required 0", overflow); end
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL rm_frame_err: %b required 0", frame_err); end
        if (sample_cnt !== 32'h0) begin n_fail++; $display("FAIL rm_sample_cnt: %0d required 0", sample_cnt); end
        areset = 1'b0;
        m_axis_tready = 1'b1;
        exp_cnt = 0;
        clk_n(4);
        send_frame(24'hDE_ADBE);
        exp_cnt++;
        expect_one("rm_after_reset", 32'hFFDE_ADBE);
        n_checks++;
        if (sample_cnt !== 32'(exp_cnt)) begin n_fail++; $display("FAIL rm_sample_cnt_after: %0d required %0d", sample_cnt, exp_cnt); end
    endtask

`ifdef ADS1675_RX_TLAST_EN
    task automatic test_tlast();
        int bad = 0;
        enable = 1'b0;
        clk_n(2);
        enable = 1'b1;
        clk_n(2);
        clear_mon();
        half = 2;
        for (int k = 0; k < 600; k++) begin
            drdy_pulse();
            send_bits(24'(k), 24);
            clk_n(4);
        end
        half = 3;
        exp_cnt += 600;
        n_checks++;
        if (got_q.size() != 600) begin
            n_fail++;
            $display("FAIL tlast_transfers: %0d required 600", got_q.size());
        end else begin
            for (int k = 0; k < 600; k++) begin
                if (last_q[k] !== ((k == 299) || (k == 599))) bad++;
            end
            if (bad != 0) begin n_fail++; $display("FAIL tlast_position: wrong=%0d required 0", bad); end
            else $display("ok   tlast on transfers 299 and 599");
        end
        n_checks++;
        if (sample_cnt !== 32'(exp_cnt)) begin n_fail++; $display("FAIL tlast_sample_cnt: %0d required %0d", sample_cnt, exp_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_positive();
        test_random();
        test_backpressure();
        test_frame_err();
        test_enable_drop();
        test_reset_mid();
`ifdef ADS1675_RX_TLAST_EN
        test_tlast();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
